// File: rtl/biriscv_icache_port_arb.sv
// biriscv_icache_port_arb
// Two fetch requesters share one instruction-cache read port. Reads are
// granted round-robin (or fixed priority) with up to DEPTH in flight. An
// in-order tag FIFO records who owns each read, so every response returns to
// that owner. Flush/invalidate requests are held pending until no read is
// outstanding, then they are issued as a single-cycle pulse.
module biriscv_icache_port_arb #(
  parameter int DEPTH      = 2,
  parameter int DEPTH_W    = 1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        req0_rd_i,
  input  logic [31:0] req0_pc_i,
  input  logic [1:0]  req0_priv_i,
  input  logic        req0_flush_i,
  input  logic        req0_invalidate_i,
  output logic        req0_accept_o,
  output logic        req0_valid_o,
  output logic [63:0] req0_inst_o,
  output logic        req0_error_o,
  output logic        req0_page_fault_o,

  input  logic        req1_rd_i,
  input  logic [31:0] req1_pc_i,
  input  logic [1:0]  req1_priv_i,
  input  logic        req1_flush_i,
  input  logic        req1_invalidate_i,
  output logic        req1_accept_o,
  output logic        req1_valid_o,
  output logic [63:0] req1_inst_o,
  output logic        req1_error_o,
  output logic        req1_page_fault_o,

  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  output logic [1:0]  icache_priv_o,
  output logic        icache_flush_o,
  output logic        icache_invalidate_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [63:0] icache_inst_i,
  input  logic        icache_error_i,
  input  logic        icache_page_fault_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_MAINT = 2'd2
  } state_t;

  localparam logic [DEPTH_W:0] CNT_DEPTH = (DEPTH_W + 1)'(DEPTH);

  state_t               state_q;
  state_t               state_d;
  logic [DEPTH_W:0]     count_q;
  logic [DEPTH_W:0]     count_d;
  logic [DEPTH_W-1:0]   wr_ptr_q;
  logic [DEPTH_W-1:0]   rd_ptr_q;
  logic                 tag_mem [DEPTH];
  logic                 last_q;
  logic                 lock_q;
  logic                 lock_owner_q;
  logic                 flush_pend_q;
  logic                 inval_pend_q;
  logic                 flush_pend_d;
  logic                 inval_pend_d;

  logic                 gnt_vld;
  logic                 gnt_owner;
  logic                 push;
  logic                 pop;
  logic                 head_owner;
  logic                 lock_d;
  logic                 pend_any;

  // Pointers wrap modulo DEPTH, which also covers DEPTH=1 (pointer stays 0).
  function automatic logic [DEPTH_W-1:0] ptr_inc(input logic [DEPTH_W-1:0] p);
    ptr_inc = (p == DEPTH_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Grant selection: IDLE only, below the outstanding limit; a stalled read keeps its owner.
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_owner = 1'b0;
    if (!rst_i && (state_q == ST_IDLE) && (count_q < CNT_DEPTH)) begin
      if (lock_q) begin
        gnt_owner = lock_owner_q;
        gnt_vld   = lock_owner_q ? req1_rd_i : req0_rd_i;
      end else if (req0_rd_i && req1_rd_i) begin
        gnt_vld   = 1'b1;
        gnt_owner = FIXED_PRIO ? 1'b0 : ~last_q;
      end else if (req0_rd_i) begin
        gnt_vld   = 1'b1;
        gnt_owner = 1'b0;
      end else if (req1_rd_i) begin
        gnt_vld   = 1'b1;
        gnt_owner = 1'b1;
      end
    end
  end

  // FIFO bookkeeping: push on accepted read, pop on response when a tag exists.
  always_comb begin
    push       = gnt_vld & icache_accept_i;
    pop        = ~rst_i & icache_valid_i & (count_q != '0);
    head_owner = tag_mem[rd_ptr_q];
    lock_d     = gnt_vld & ~icache_accept_i;
    pend_any   = flush_pend_q | inval_pend_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A pulse arriving in MAINT survives the clear of the bit it would set.
    flush_pend_d = ((state_q == ST_MAINT) ? 1'b0 : flush_pend_q) | req0_flush_i | req1_flush_i;
    inval_pend_d = ((state_q == ST_MAINT) ? 1'b0 : inval_pend_q) | req0_invalidate_i | req1_invalidate_i;
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: leave IDLE only once no read is stalled; skip DRAIN if already empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_any && !lock_d)
          state_d = (count_d == '0) ? ST_MAINT : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (count_d == '0)
          state_d = ST_MAINT;
      end
      ST_MAINT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: read port, maintenance pulses, and owner-routed accept/response.
  always_comb begin
    icache_rd_o         = gnt_vld;
    icache_pc_o         = '0;
    icache_priv_o       = '0;
    if (gnt_vld) begin
      icache_pc_o   = gnt_owner ? req1_pc_i   : req0_pc_i;
      icache_priv_o = gnt_owner ? req1_priv_i : req0_priv_i;
    end
    icache_flush_o      = ~rst_i & (state_q == ST_MAINT) & flush_pend_q;
    icache_invalidate_o = ~rst_i & (state_q == ST_MAINT) & inval_pend_q;

    req0_accept_o       = push & ~gnt_owner;
    req1_accept_o       = push &  gnt_owner;

    req0_valid_o        = pop & ~head_owner;
    req1_valid_o        = pop &  head_owner;
    req0_inst_o         = req0_valid_o ? icache_inst_i : '0;
    req1_inst_o         = req1_valid_o ? icache_inst_i : '0;
    req0_error_o        = req0_valid_o & icache_error_i;
    req1_error_o        = req1_valid_o & icache_error_i;
    req0_page_fault_o   = req0_valid_o & icache_page_fault_i;
    req1_page_fault_o   = req1_valid_o & icache_page_fault_i;
  end

  // Control state: counters, pointers, arbitration history, lock and pending bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_q       <= 1'b1;
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      flush_pend_q <= 1'b0;
      inval_pend_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        last_q   <= gnt_owner;
      end
      if (pop)
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      lock_q       <= lock_d;
      if (lock_d)
        lock_owner_q <= gnt_owner;
      flush_pend_q <= flush_pend_d;
      inval_pend_q <= inval_pend_d;
    end
  end

  // Tag storage: owner of each accepted read; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push)
      tag_mem[wr_ptr_q] <= gnt_owner;
  end

endmodule

// File: tb/tb_biriscv_icache_port_arb.sv
// Testbench for biriscv_icache_port_arb: directed vectors, scoreboard queues
// filled by the stimulus and drained by a negedge monitor.
module tb_biriscv_icache_port_arb;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req0_rd_i, req1_rd_i;
  logic [31:0] req0_pc_i, req1_pc_i;
  logic [1:0]  req0_priv_i, req1_priv_i;
  logic        req0_flush_i, req1_flush_i, req0_invalidate_i, req1_invalidate_i;
  logic        icache_accept_i, icache_valid_i, icache_error_i, icache_page_fault_i;
  logic [63:0] icache_inst_i;

  logic        req0_accept_o, req0_valid_o, req0_error_o, req0_page_fault_o;
  logic        req1_accept_o, req1_valid_o, req1_error_o, req1_page_fault_o;
  logic [63:0] req0_inst_o, req1_inst_o;
  logic        icache_rd_o, icache_flush_o, icache_invalidate_o;
  logic [31:0] icache_pc_o;
  logic [1:0]  icache_priv_o;

  logic        fp_req0_accept_o, fp_req0_valid_o, fp_req0_error_o, fp_req0_page_fault_o;
  logic        fp_req1_accept_o, fp_req1_valid_o, fp_req1_error_o, fp_req1_page_fault_o;
  logic [63:0] fp_req0_inst_o, fp_req1_inst_o;
  logic        fp_icache_rd_o, fp_icache_flush_o, fp_icache_invalidate_o;
  logic [31:0] fp_icache_pc_o;
  logic [1:0]  fp_icache_priv_o;

  always #5 clk = ~clk;

  biriscv_icache_port_arb #(.DEPTH(2), .DEPTH_W(1), .FIXED_PRIO(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_rd_i(req0_rd_i), .req0_pc_i(req0_pc_i), .req0_priv_i(req0_priv_i),
    .req0_flush_i(req0_flush_i), .req0_invalidate_i(req0_invalidate_i),
    .req0_accept_o(req0_accept_o), .req0_valid_o(req0_valid_o), .req0_inst_o(req0_inst_o),
    .req0_error_o(req0_error_o), .req0_page_fault_o(req0_page_fault_o),
    .req1_rd_i(req1_rd_i), .req1_pc_i(req1_pc_i), .req1_priv_i(req1_priv_i),
    .req1_flush_i(req1_flush_i), .req1_invalidate_i(req1_invalidate_i),
    .req1_accept_o(req1_accept_o), .req1_valid_o(req1_valid_o), .req1_inst_o(req1_inst_o),
    .req1_error_o(req1_error_o), .req1_page_fault_o(req1_page_fault_o),
    .icache_rd_o(icache_rd_o), .icache_pc_o(icache_pc_o), .icache_priv_o(icache_priv_o),
    .icache_flush_o(icache_flush_o), .icache_invalidate_o(icache_invalidate_o),
    .icache_accept_i(icache_accept_i), .icache_valid_i(icache_valid_i),
    .icache_inst_i(icache_inst_i), .icache_error_i(icache_error_i),
    .icache_page_fault_i(icache_page_fault_i)
  );

  biriscv_icache_port_arb #(.DEPTH(2), .DEPTH_W(1), .FIXED_PRIO(1'b1)) u_fp (
    .clk_i(clk), .rst_i(rst_i),
    .req0_rd_i(req0_rd_i), .req0_pc_i(req0_pc_i), .req0_priv_i(req0_priv_i),
    .req0_flush_i(req0_flush_i), .req0_invalidate_i(req0_invalidate_i),
    .req0_accept_o(fp_req0_accept_o), .req0_valid_o(fp_req0_valid_o), .req0_inst_o(fp_req0_inst_o),
    .req0_error_o(fp_req0_error_o), .req0_page_fault_o(fp_req0_page_fault_o),
    .req1_rd_i(req1_rd_i), .req1_pc_i(req1_pc_i), .req1_priv_i(req1_priv_i),
    .req1_flush_i(req1_flush_i), .req1_invalidate_i(req1_invalidate_i),
    .req1_accept_o(fp_req1_accept_o), .req1_valid_o(fp_req1_valid_o), .req1_inst_o(fp_req1_inst_o),
    .req1_error_o(fp_req1_error_o), .req1_page_fault_o(fp_req1_page_fault_o),
    .icache_rd_o(fp_icache_rd_o), .icache_pc_o(fp_icache_pc_o), .icache_priv_o(fp_icache_priv_o),
    .icache_flush_o(fp_icache_flush_o), .icache_invalidate_o(fp_icache_invalidate_o),
    .icache_accept_i(icache_accept_i), .icache_valid_i(icache_valid_i),
    .icache_inst_i(icache_inst_i), .icache_error_i(icache_error_i),
    .icache_page_fault_i(icache_page_fault_i)
  );

  typedef struct packed { logic owner; logic [31:0] pc; } gnt_t;
  typedef struct packed { logic owner; logic [63:0] inst; logic err; logic pf; } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  int   total = 0;
  int   bad   = 0;

  logic [63:0] rr_data [4] = '{64'hA0A0_0000_0000_0001, 64'hB1B1_0000_0000_0002,
                               64'hA2A2_0000_0000_0003, 64'hB3B3_0000_0000_0004};

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic rsp(input logic owner, input logic [63:0] d, input logic e, input logic p);
    icache_valid_i      = 1'b1;
    icache_inst_i       = d;
    icache_error_i      = e;
    icache_page_fault_i = p;
    rq.push_back('{owner: owner, inst: d, err: e, pf: p});
  endtask

  // Monitor: every accepted read and every routed response is matched against the queues.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (icache_rd_o && icache_accept_i) begin
        if (gq.size() == 0) begin
          chk("grant_unexpected", {icache_pc_o}, 256'd0);
        end else begin
          gnt_t g;
          g = gq.pop_front();
          chk("grant", {req0_accept_o, req1_accept_o, icache_pc_o},
              {~g.owner, g.owner, g.pc});
        end
      end
      if (req0_valid_o || req1_valid_o) begin
        if (rq.size() == 0) begin
          chk("rsp_unexpected", {req0_valid_o, req1_valid_o}, 256'd0);
        end else begin
          rsp_t r;
          r = rq.pop_front();
          chk("rsp",
              {req0_valid_o, req1_valid_o, req0_inst_o, req1_inst_o,
               req0_error_o, req1_error_o, req0_page_fault_o, req1_page_fault_o},
              {~r.owner, r.owner, r.owner ? 64'd0 : r.inst, r.owner ? r.inst : 64'd0,
               ~r.owner & r.err, r.owner & r.err, ~r.owner & r.pf, r.owner & r.pf});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    req0_rd_i = 1'b0; req1_rd_i = 1'b0;
    req0_pc_i = '0; req1_pc_i = '0; req0_priv_i = '0; req1_priv_i = '0;
    req0_flush_i = 1'b0; req1_flush_i = 1'b0;
    req0_invalidate_i = 1'b0; req1_invalidate_i = 1'b0;
    icache_accept_i = 1'b0; icache_valid_i = 1'b0;
    icache_inst_i = '0; icache_error_i = 1'b0; icache_page_fault_i = 1'b0;

    // Reset: outputs held at 0 even with live requests and responses.
    req0_rd_i = 1'b1; icache_accept_i = 1'b1; icache_valid_i = 1'b1;
    icache_inst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    tick(); tick();
    chk("reset_rd", {icache_rd_o, icache_pc_o, req0_accept_o, req1_accept_o}, 256'd0);
    chk("reset_rsp", {req0_valid_o, req1_valid_o, req0_inst_o, icache_flush_o, icache_invalidate_o}, 256'd0);
    req0_rd_i = 1'b0; icache_accept_i = 1'b0; icache_valid_i = 1'b0; icache_inst_i = '0;
    rst_i = 1'b0;

    // Single requester read and response two cycles later.
    tick();
    req0_rd_i = 1'b1; req0_pc_i = 32'h8000_0000; req0_priv_i = 2'd3; icache_accept_i = 1'b1;
    gq.push_back('{owner: 1'b0, pc: 32'h8000_0000});
    #1;
    chk("single_accept", {req0_accept_o, req1_accept_o, icache_priv_o}, {1'b1, 1'b0, 2'd3});
    tick();
    req0_rd_i = 1'b0; icache_accept_i = 1'b0;
    tick();
    rsp(1'b0, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    #1;
    chk("single_other_quiet", {req1_valid_o, req1_inst_o}, 256'd0);
    tick();
    icache_valid_i = 1'b0;

    // Round-robin contention; the fixed-priority copy must pick req0 every time.
    reset_dut();
    req0_pc_i = 32'h100; req1_pc_i = 32'h200; req0_priv_i = 2'd0;
    for (int i = 0; i < 5; i++) begin
      logic odd;
      logic podd;
      odd  = i[0];
      podd = ~i[0];
      req0_rd_i = (i < 4); req1_rd_i = (i < 4); icache_accept_i = (i < 4);
      icache_valid_i = 1'b0;
      if (i < 4) gq.push_back('{owner: odd, pc: odd ? 32'h200 : 32'h100});
      if (i >= 1) rsp(podd, rr_data[i-1], (i == 2), (i == 3));
      #1;
      if (i < 4) chk("fixed_prio_grant", {fp_req0_accept_o, fp_req1_accept_o}, 2'b10);
      tick();
    end
    req0_rd_i = 1'b0; req1_rd_i = 1'b0; icache_accept_i = 1'b0;
    icache_valid_i = 1'b0; icache_error_i = 1'b0; icache_page_fault_i = 1'b0;

    // Backpressure lock: req0 stalled for 3 cycles, req1 arrives and must wait.
    req0_rd_i = 1'b1; req0_pc_i = 32'h2F0; icache_accept_i = 1'b1;
    gq.push_back('{owner: 1'b0, pc: 32'h2F0});
    tick();
    req0_pc_i = 32'h300; icache_accept_i = 1'b0;
    #1;
    chk("lock_c0", icache_pc_o, 32'h300);
    tick();
    req1_rd_i = 1'b1; req1_pc_i = 32'h400;
    #1;
    chk("lock_c1", {icache_rd_o, icache_pc_o}, {1'b1, 32'h300});
    tick();
    #1;
    chk("lock_c2", {icache_rd_o, icache_pc_o}, {1'b1, 32'h300});
    tick();
    icache_accept_i = 1'b1;
    gq.push_back('{owner: 1'b0, pc: 32'h300});
    rsp(1'b0, 64'h0000_02F0_0000_02F0, 1'b0, 1'b0);
    #1;
    chk("lock_release", icache_pc_o, 32'h300);
    tick();
    req0_rd_i = 1'b0; icache_valid_i = 1'b0;
    gq.push_back('{owner: 1'b1, pc: 32'h400});
    #1;
    chk("lock_next_req1", {req1_accept_o, icache_pc_o}, {1'b1, 32'h400});
    tick();

    // Full: two outstanding, req1 keeps requesting.
    req1_pc_i = 32'h500;
    #1;
    chk("full_block0", {icache_rd_o, req1_accept_o}, 2'b00);
    tick();
    #1;
    chk("full_block1", {icache_rd_o, req1_accept_o}, 2'b00);
    tick();
    rsp(1'b0, 64'h0000_0300_0000_0300, 1'b0, 1'b0);
    #1;
    chk("full_same_cycle_pop", icache_rd_o, 1'b0);
    tick();
    icache_valid_i = 1'b0;
    gq.push_back('{owner: 1'b1, pc: 32'h500});
    #1;
    chk("full_resume", {icache_rd_o, icache_pc_o}, {1'b1, 32'h500});
    tick();

    // Flush drain with two outstanding (0x400, 0x500).
    req1_rd_i = 1'b0; req1_flush_i = 1'b1;
    req0_rd_i = 1'b1; req0_pc_i = 32'h600;
    #1;
    chk("flush_c0", {icache_rd_o, icache_flush_o}, 2'b00);
    tick();
    req1_flush_i = 1'b0;
    rsp(1'b1, 64'h0000_0400_0000_0400, 1'b0, 1'b0);
    #1;
    chk("flush_c1", {icache_rd_o, icache_flush_o}, 2'b00);
    tick();
    icache_valid_i = 1'b0;
    #1;
    chk("flush_drain", {icache_rd_o, icache_flush_o}, 2'b00);
    tick();
    rsp(1'b1, 64'h0000_0500_0000_0500, 1'b0, 1'b0);
    #1;
    chk("flush_last_rsp", {icache_rd_o, icache_flush_o}, 2'b00);
    tick();
    icache_valid_i = 1'b0;
    #1;
    chk("flush_pulse", {icache_rd_o, icache_flush_o, icache_invalidate_o}, 3'b010);
    tick();
    gq.push_back('{owner: 1'b0, pc: 32'h600});
    #1;
    chk("flush_resume", {icache_rd_o, icache_flush_o, icache_pc_o}, {2'b10, 32'h600});
    tick();
    req0_rd_i = 1'b0;
    rsp(1'b0, 64'h0000_0600_0000_0600, 1'b0, 1'b0);
    tick();
    icache_valid_i = 1'b0;

    // Asynchronous reset with one read outstanding.
    req0_rd_i = 1'b1; req0_pc_i = 32'h700;
    gq.push_back('{owner: 1'b0, pc: 32'h700});
    tick();
    req0_pc_i = 32'h708; icache_accept_i = 1'b0;
    #1;
    chk("pre_reset_rd", {icache_rd_o, icache_pc_o}, {1'b1, 32'h708});
    #1;
    rst_i = 1'b1;
    icache_valid_i = 1'b1; icache_inst_i = 64'h5555_6666_7777_8888;
    #1;
    chk("async_reset_out", {icache_rd_o, icache_pc_o, req0_accept_o, req0_valid_o, req0_inst_o},
        256'd0);
    tick();
    rst_i = 1'b0; req0_rd_i = 1'b0;
    #1;
    chk("stray_rsp", {req0_valid_o, req1_valid_o, req0_inst_o, req1_inst_o}, 256'd0);
    tick();
    icache_valid_i = 1'b0;
    tick();
    tick();

    chk("grant_queue_empty", gq.size(), 0);
    chk("rsp_queue_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/biriscv_icache_port_arb.md
Name: biriscv_icache_port_arb

Overview:
- Arbitrates one instruction-cache read port between two fetch requesters.
  - Requester 0: main fetch unit.
  - Requester 1: secondary fetch source, e.g. prefetcher or debug fetch.
- Issues at most DEPTH outstanding reads.
- Records the owner of each issued read in an in-order tag FIFO and routes every response back to that owner.
- Sequences flush/invalidate requests so they reach the cache only when no read is outstanding.

Parameters:
DEPTH, 2, max outstanding icache reads (power of 2, >=1)
DEPTH_W, 1, log2(DEPTH) (≥1)
FIXED_PRIO, 0, 1 = requester 0 always wins; 0 = round-robin

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
reqN_rd_i  in  1  read request (N=0,1); held with pc/priv until accepted
reqN_pc_i  in  32  fetch address
reqN_priv_i  in  2  privilege level
reqN_flush_i  in  1  flush request pulse
reqN_invalidate_i  in  1  invalidate request pulse
reqN_accept_o  out  1  read accepted this cycle
reqN_valid_o  out  1  response valid
reqN_inst_o  out  64  response data
reqN_error_o  out  1  bus error
reqN_page_fault_o  out  1  page fault
icache_rd_o  out  1  read request
icache_pc_o  out  32  read address
icache_priv_o  out  2  privilege level
icache_flush_o  out  1  flush pulse
icache_invalidate_o  out  1  invalidate pulse
icache_accept_i  in  1  read accepted
icache_valid_i  in  1  response valid
icache_inst_i  in  64  response data
icache_error_i  in  1  response error
icache_page_fault_i  in  1  response page fault

Behaviour:
- Reset (async, rst_i=1):
  - All outputs 0.
  - Tag FIFO empty; outstanding count 0.
  - Round-robin last-grant = 1, so requester 0 wins the first contest.
  - State IDLE; flush/invalidate pending bits cleared.
  - Reset mid-transaction discards in-flight tags; responses arriving after reset release are dropped.
- States:
  - IDLE: issue reads.
  - DRAIN: maintenance pending; no new reads; wait for outstanding==0.
  - MAINT: one cycle; drive the pulses.
  - IDLE→DRAIN when any pending bit is set at a cycle edge.
  - DRAIN→MAINT when count==0 (DRAIN lasts 0 cycles if already empty: IDLE→MAINT directly).
  - MAINT→IDLE unconditionally.
- Pending bits:
  - flush_pend |= req0_flush_i | req1_flush_i; inval_pend likewise.
  - In MAINT: icache_flush_o=flush_pend, icache_invalidate_o=inval_pend; both bits clear.
  - A pulse arriving during MAINT is not lost: set-during-clear leaves the bit set.
- Grant (IDLE only, count<DEPTH, no grant lock):
  - Both requesting: FIXED_PRIO=1 gives req0; otherwise the requester not granted last.
  - Grant is combinational to icache_rd_o/pc/priv in the same cycle.
- Lock: if icache_rd_o=1 and icache_accept_i=0, the grant stays locked to the same requester until accept, regardless of the other requester or new pending maintenance. Transition to DRAIN waits until the lock releases.
- On icache_rd_o & icache_accept_i:
  - reqN_accept_o=1 for the owner (combinational).
  - Owner tag pushed; count++.
  - last-grant updated.
- Response:
  - On icache_valid_i, pop head tag; count--.
  - Assert reqN_valid_o with inst/error/page_fault passthrough (combinational, 0-cycle latency) for the owner only.
  - Non-owner data outputs driven 0.
  - icache_valid_i with an empty FIFO is ignored.
- Full: count==DEPTH blocks new grants; icache_rd_o=0.
- Same-cycle accept+response at full is allowed: count unchanged and the grant is evaluated with count<DEPTH using the pre-pop count. Consequently at full no grant occurs that cycle.
- Counter width DEPTH_W+1; FIFO pointers wrap modulo DEPTH.

Test Plan:
- Single requester: req0 rd pc=0x8000_0000, accept same cycle → req0_accept_o=1; 2 cycles later icache_valid_i inst=0x1111_2222_3333_4444 → req0_valid_o=1 with that data, req1_valid_o=0.
- Round-robin contention, FIXED_PRIO=0, accept every cycle, both rd held for 4 grants:
  - Grant order 0,1,0,1; icache_pc_o alternates 0x100/0x200.
  - Responses routed 0,1,0,1.
  - With FIXED_PRIO=1: 0,0,0,0.
- Backpressure lock: req0 granted, icache_accept_i=0 for 3 cycles while req1 rises → icache_pc_o stays req0 pc; req1 granted next after accept.
- Full: DEPTH=2, two accepted, no response → icache_rd_o=0 despite req1_rd_i; one icache_valid_i → grant resumes the next cycle.
- Flush drain: 2 outstanding, req1_flush_i pulse → no icache_rd_o; after 2nd response, exactly one cycle icache_flush_o=1, invalidate 0; then reads resume.
- Async reset mid-read: rst_i asserted between clock edges with 1 outstanding → outputs 0 immediately; post-reset stray icache_valid_i produces no reqN_valid_o.
